// File: rtl/bm1387_pkg.sv
// Shared definitions for the BM1387 behavioural model.
// Contents: FSM state encoding, hash-core round constant, lane access and
// one-round mixing helper, and the bit offsets of the HNS colour fields
// inside a 256-bit hash.
package bm1387_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HASH = 2'd1,
        S_HNS  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    localparam logic [31:0] ROUND_CONST = 32'h9E3779B9;
    localparam int          ROT_AMT     = 7;
    localparam int          LANES       = 8;

    // LSB positions of the 24-bit colour fields within the hash
    localparam int R_LSB = 232;
    localparam int G_LSB = 168;
    localparam int B_LSB = 104;
    localparam int A_LSB = 40;

    function automatic logic [31:0] rotl32(input logic [31:0] x);
        return (x << ROT_AMT) | (x >> (32 - ROT_AMT));
    endfunction

    // Lane k occupies h[32k+31:32k]; lane 7 is the most significant word
    function automatic logic [31:0] lane(input logic [255:0] h, input int k);
        return h[k*32 +: 32];
    endfunction

    // One mixing round; all lanes update from the previous round's values
    function automatic logic [255:0] mix_round(input logic [255:0] h,
                                               input logic [31:0]  idx);
        logic [255:0] res;
        logic [31:0]  kc;
        kc = ROUND_CONST * (idx + 32'd1);
        for (int k = 0; k < LANES; k++) begin
            res[k*32 +: 32] = rotl32(lane(h, k)) ^ (lane(h, (k + 1) % LANES) + kc);
        end
        return res;
    endfunction

endpackage

// File: rtl/bm1387_asic_hns_mapper.sv
// Combinational HNS post-processing of one 256-bit hash.
// Ports:
//   h_i          hash to map
//   a_prev_i     alpha channel of the previously mapped hash
//   r_o..a_o     24-bit colour channels
//   mag_o        vector magnitude, (max(r,g,b) >> 1) | 1
//   energy_o     (r+g+b+a) >> 2
//   entropy_o    popcount(h) << 16
//   phi_o        (entropy >> 1) + (mag >> 1)
//   phase_coh_o  (0xFFFFFF - |a - a_prev|) | 1
module bm1387_hns_mapper
    import bm1387_pkg::*;
(
    input  logic [255:0] h_i,
    input  logic [23:0]  a_prev_i,
    output logic [23:0]  r_o,
    output logic [23:0]  g_o,
    output logic [23:0]  b_o,
    output logic [23:0]  a_o,
    output logic [31:0]  mag_o,
    output logic [31:0]  energy_o,
    output logic [31:0]  entropy_o,
    output logic [31:0]  phi_o,
    output logic [31:0]  phase_coh_o
);

    logic [23:0] max_rg;
    logic [23:0] max_rgb;
    logic [23:0] a_diff;
    logic [25:0] sum;
    logic [8:0]  pop;

    assign r_o = h_i[R_LSB +: 24];
    assign g_o = h_i[G_LSB +: 24];
    assign b_o = h_i[B_LSB +: 24];
    assign a_o = h_i[A_LSB +: 24];

    assign max_rg  = (r_o > g_o) ? r_o : g_o;
    assign max_rgb = (max_rg > b_o) ? max_rg : b_o;
    assign mag_o   = {8'b0, (max_rgb >> 1) | 24'd1};

    // 26 bits hold four 24-bit terms without overflow
    assign sum      = 26'(r_o) + 26'(g_o) + 26'(b_o) + 26'(a_o);
    assign energy_o = {6'b0, sum} >> 2;

    always_comb begin
        pop = '0;
        for (int i = 0; i < 256; i++) begin
            pop = pop + 9'(h_i[i]);
        end
    end

    assign entropy_o = {7'b0, pop, 16'b0};
    assign phi_o     = (entropy_o >> 1) + (mag_o >> 1);

    assign a_diff      = (a_o >= a_prev_i) ? (a_o - a_prev_i) : (a_prev_i - a_o);
    assign phase_coh_o = {8'b0, (24'hFFFFFF - a_diff) | 24'd1};

endmodule

// File: rtl/bm1387_asic.sv
// BM1387 mining-ASIC behavioural model with HNS post-processing.
// Iterates nonces over a job header through a simplified 8-lane hash core
// (one round per cycle), maps each hash to colour/metric outputs, checks a
// leading-zero difficulty target, and models temperature, power, throttle.
// Ports:
//   clk_100m, reset_n      clock; synchronous reset, high = reset
//   job_header/start_nonce/nonce_range/mining_enable   job request
//   control_reg[0]         run enable; config_reg[4:0] difficulty
//   found_nonce/found_hash/hash_valid                   target hits
//   pipeline_busy, temperature, power_consumption, thermal_throttle
//   status_reg             {busy, hns_valid, found_sticky, throttle, 2'b0, state}
//   hns_*                  registered HNS outputs, hns_valid qualifier
//   uart/spi               unused tie-offs
//   debug_reg_0..3         live only when BM1387_DEBUG_EN is defined
module bm1387_asic
    import bm1387_pkg::*;
#(
    parameter int HASH_ROUNDS   = 8,
    parameter int TEMP_BASE     = 40,
    parameter int THROTTLE_TEMP = 85,
    parameter int P_IDLE        = 500,
    parameter int P_ACTIVE      = 1200
) (
    input  logic         clk_100m,
    input  logic         reset_n,
    input  logic [255:0] job_header,
    input  logic [31:0]  start_nonce,
    input  logic [31:0]  nonce_range,
    input  logic         mining_enable,
    output logic [31:0]  found_nonce,
    output logic [255:0] found_hash,
    output logic         hash_valid,
    output logic         pipeline_busy,
    output logic [7:0]   temperature,
    output logic [15:0]  power_consumption,
    output logic         thermal_throttle,
    input  logic [7:0]   control_reg,
    output logic [7:0]   status_reg,
    input  logic [15:0]  config_reg,
    input  logic         uart_rx,
    output logic         uart_tx,
    input  logic         spi_clk,
    input  logic         spi_cs_n,
    input  logic         spi_mosi,
    output logic         spi_miso,
    output logic [31:0]  hns_rgba_r,
    output logic [31:0]  hns_rgba_g,
    output logic [31:0]  hns_rgba_b,
    output logic [31:0]  hns_rgba_a,
    output logic [31:0]  hns_vector_mag,
    output logic [31:0]  hns_energy,
    output logic [31:0]  hns_entropy,
    output logic [31:0]  hns_phi,
    output logic [31:0]  hns_phase_coh,
    output logic         hns_valid,
    output logic [31:0]  debug_reg_0,
    output logic [31:0]  debug_reg_1,
    output logic [31:0]  debug_reg_2,
    output logic [31:0]  debug_reg_3
);

    localparam int          CNT_W      = $clog2(HASH_ROUNDS + 1);
    localparam logic [7:0]  TEMP_BASE_C = 8'(TEMP_BASE);
    localparam logic [7:0]  THROTTLE_C  = 8'(THROTTLE_TEMP);

    state_e         state_q, state_d;
    logic [255:0]   hdr_q, hdr_d;
    logic [255:0]   h_q, h_d;
    logic [31:0]    nonce_q, nonce_d;
    logic [31:0]    remain_q, remain_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic           tog_q, tog_d;
    logic           hv_q, hv_d;
    logic           hit_pulse_q, hit_pulse_d;
    logic           sticky_q, sticky_d;
    logic [31:0]    fnonce_q, fnonce_d;
    logic [255:0]   fhash_q, fhash_d;
    logic [23:0]    a_prev_q, a_prev_d;
    logic [31:0]    r_q, g_q, b_q, a_q, mag_q, energy_q, entropy_q, phi_q, pc_q;
    logic [31:0]    r_d, g_d, b_d, a_d, mag_d, energy_d, entropy_d, phi_d, pc_d;
    logic [7:0]     temp_q, temp_d;
    logic [5:0]     tick_q, tick_d;

    logic [23:0]    m_r, m_g, m_b, m_a;
    logic [31:0]    m_mag, m_energy, m_entropy, m_phi, m_pc;
    logic           busy_w;
    logic           throttle_w;
    logic           hit_w;
    logic [31:0]    top_lane;
    logic [4:0]     diff_bits;

    bm1387_hns_mapper u_mapper (
        .h_i         (h_q),
        .a_prev_i    (a_prev_q),
        .r_o         (m_r),
        .g_o         (m_g),
        .b_o         (m_b),
        .a_o         (m_a),
        .mag_o       (m_mag),
        .energy_o    (m_energy),
        .entropy_o   (m_entropy),
        .phi_o       (m_phi),
        .phase_coh_o (m_pc)
    );

    assign busy_w     = (state_q == S_HASH) || (state_q == S_HNS);
    assign throttle_w = (temp_q >= THROTTLE_C);

    // Target: the top D bits of the hash must all be zero
    assign top_lane  = h_q[255:224];
    assign diff_bits = config_reg[4:0];
    assign hit_w     = (diff_bits == 5'd0) ||
                       ((top_lane >> (6'd32 - {1'b0, diff_bits})) == 32'd0);

    always_comb begin
        state_d     = state_q;
        hdr_d       = hdr_q;
        h_d         = h_q;
        nonce_d     = nonce_q;
        remain_d    = remain_q;
        cnt_d       = cnt_q;
        tog_d       = tog_q;
        hv_d        = hv_q;
        hit_pulse_d = 1'b0;
        sticky_d    = sticky_q;
        fnonce_d    = fnonce_q;
        fhash_d     = fhash_q;
        a_prev_d    = a_prev_q;
        r_d = r_q; g_d = g_q; b_d = b_q; a_d = a_q;
        mag_d = mag_q; energy_d = energy_q; entropy_d = entropy_q;
        phi_d = phi_q; pc_d = pc_q;

        unique case (state_q)
            S_IDLE: begin
                hv_d = 1'b0;
                if (mining_enable && control_reg[0]) begin
                    state_d  = S_HASH;
                    hdr_d    = job_header;
                    nonce_d  = start_nonce;
                    remain_d = (nonce_range == 32'd0) ? 32'd1 : nonce_range;
                    cnt_d    = '0;
                    tog_d    = 1'b0;
                    sticky_d = 1'b0;
                end
            end
            S_HASH: begin
                if (cnt_q == '0) begin
                    // Seed cycle: fold the nonce into every lane
                    h_d   = hdr_q ^ {8{nonce_q}};
                    cnt_d = CNT_W'(1);
                end else if (!throttle_w || tog_q) begin
                    h_d   = mix_round(h_q, 32'(cnt_q) - 32'd1);
                    tog_d = 1'b0;
                    if (cnt_q == CNT_W'(HASH_ROUNDS)) begin
                        state_d = S_HNS;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    // Throttled: skip this cycle, advance on the next one
                    tog_d = 1'b1;
                end
            end
            S_HNS: begin
                r_d       = {8'b0, m_r};
                g_d       = {8'b0, m_g};
                b_d       = {8'b0, m_b};
                a_d       = {8'b0, m_a};
                mag_d     = m_mag;
                energy_d  = m_energy;
                entropy_d = m_entropy;
                phi_d     = m_phi;
                pc_d      = m_pc;
                a_prev_d  = m_a;
                hv_d      = 1'b1;
                if (hit_w) begin
                    fnonce_d    = nonce_q;
                    fhash_d     = h_q;
                    hit_pulse_d = 1'b1;
                    sticky_d    = 1'b1;
                end
                remain_d = remain_q - 32'd1;
                nonce_d  = nonce_q + 32'd1;
                if (remain_q != 32'd1) begin
                    state_d = S_HASH;
                    cnt_d   = '0;
                    tog_d   = 1'b0;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        // Dropping the run request aborts from any state
        if (!mining_enable) begin
            state_d = S_IDLE;
            hv_d    = 1'b0;
        end
    end

    always_comb begin
        temp_d = temp_q;
        tick_d = tick_q + 6'd1;
        if (tick_q == 6'd63) begin
            if (busy_w) begin
                if (temp_q != 8'hFF) temp_d = temp_q + 8'd1;
            end else if (temp_q > TEMP_BASE_C) begin
                temp_d = temp_q - 8'd1;
            end else if (temp_q < TEMP_BASE_C) begin
                temp_d = temp_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_100m) begin
        if (reset_n) begin
            state_q     <= S_IDLE;
            hdr_q       <= '0;
            h_q         <= '0;
            nonce_q     <= '0;
            remain_q    <= '0;
            cnt_q       <= '0;
            tog_q       <= 1'b0;
            hv_q        <= 1'b0;
            hit_pulse_q <= 1'b0;
            sticky_q    <= 1'b0;
            fnonce_q    <= '0;
            fhash_q     <= '0;
            a_prev_q    <= '0;
            r_q <= '0; g_q <= '0; b_q <= '0; a_q <= '0;
            mag_q <= '0; energy_q <= '0; entropy_q <= '0; phi_q <= '0; pc_q <= '0;
            temp_q      <= TEMP_BASE_C;
            tick_q      <= '0;
        end else begin
            state_q     <= state_d;
            hdr_q       <= hdr_d;
            h_q         <= h_d;
            nonce_q     <= nonce_d;
            remain_q    <= remain_d;
            cnt_q       <= cnt_d;
            tog_q       <= tog_d;
            hv_q        <= hv_d;
            hit_pulse_q <= hit_pulse_d;
            sticky_q    <= sticky_d;
            fnonce_q    <= fnonce_d;
            fhash_q     <= fhash_d;
            a_prev_q    <= a_prev_d;
            r_q <= r_d; g_q <= g_d; b_q <= b_d; a_q <= a_d;
            mag_q <= mag_d; energy_q <= energy_d; entropy_q <= entropy_d;
            phi_q <= phi_d; pc_q <= pc_d;
            temp_q      <= temp_d;
            tick_q      <= tick_d;
        end
    end

    assign found_nonce       = fnonce_q;
    assign found_hash        = fhash_q;
    assign hash_valid        = hit_pulse_q;
    assign pipeline_busy     = busy_w;
    assign temperature       = temp_q;
    assign power_consumption = busy_w ? 16'(P_ACTIVE) : 16'(P_IDLE);
    assign thermal_throttle  = throttle_w;
    assign status_reg        = {busy_w, hv_q, sticky_q, throttle_w, 2'b00, state_q};
    assign uart_tx           = 1'b1;
    assign spi_miso          = 1'b0;
    assign hns_rgba_r        = r_q;
    assign hns_rgba_g        = g_q;
    assign hns_rgba_b        = b_q;
    assign hns_rgba_a        = a_q;
    assign hns_vector_mag    = mag_q;
    assign hns_energy        = energy_q;
    assign hns_entropy       = entropy_q;
    assign hns_phi           = phi_q;
    assign hns_phase_coh     = pc_q;
    assign hns_valid         = hv_q;

    logic unused_inputs;
    assign unused_inputs = ^{uart_rx, spi_clk, spi_cs_n, spi_mosi,
                             control_reg[7:1], config_reg[15:5]};

`ifdef BM1387_DEBUG_EN
    logic [31:0] dbg_hashes_q;
    logic [31:0] dbg_hits_q;
    logic [1:0]  state_bits;

    assign state_bits = state_q;

    always_ff @(posedge clk_100m) begin
        if (reset_n) begin
            dbg_hashes_q <= '0;
            dbg_hits_q   <= '0;
        end else if (state_q == S_HNS) begin
            dbg_hashes_q <= dbg_hashes_q + 32'd1;
            if (hit_w) dbg_hits_q <= dbg_hits_q + 32'd1;
        end
    end

    assign debug_reg_0 = nonce_q;
    assign debug_reg_1 = dbg_hashes_q;
    assign debug_reg_2 = dbg_hits_q;
    assign debug_reg_3 = {22'b0, state_bits, temp_q};
`else
    assign debug_reg_0 = '0;
    assign debug_reg_1 = '0;
    assign debug_reg_2 = '0;
    assign debug_reg_3 = '0;
`endif

endmodule

// File: tb/tb_bm1387_asic.sv
module tb_bm1387_asic;

    localparam int ROUNDS = 8;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [255:0] job_header;
    logic [31:0]  start_nonce;
    logic [31:0]  nonce_range;
    logic         mining_enable;
    logic [31:0]  found_nonce;
    logic [255:0] found_hash;
    logic         hash_valid;
    logic         pipeline_busy;
    logic [7:0]   temperature;
    logic [15:0]  power_consumption;
    logic         thermal_throttle;
    logic [7:0]   control_reg;
    logic [7:0]   status_reg;
    logic [15:0]  config_reg;
    logic         uart_rx, uart_tx, spi_clk, spi_cs_n, spi_mosi, spi_miso;
    logic [31:0]  hns_rgba_r, hns_rgba_g, hns_rgba_b, hns_rgba_a;
    logic [31:0]  hns_vector_mag, hns_energy, hns_entropy, hns_phi, hns_phase_coh;
    logic         hns_valid;
    logic [31:0]  debug_reg_0, debug_reg_1, debug_reg_2, debug_reg_3;

    always #5 clk = ~clk;

    bm1387_asic dut (
        .clk_100m(clk), .reset_n(reset_n), .job_header(job_header),
        .start_nonce(start_nonce), .nonce_range(nonce_range),
        .mining_enable(mining_enable), .found_nonce(found_nonce),
        .found_hash(found_hash), .hash_valid(hash_valid),
        .pipeline_busy(pipeline_busy), .temperature(temperature),
        .power_consumption(power_consumption), .thermal_throttle(thermal_throttle),
        .control_reg(control_reg), .status_reg(status_reg), .config_reg(config_reg),
        .uart_rx(uart_rx), .uart_tx(uart_tx), .spi_clk(spi_clk),
        .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .hns_rgba_r(hns_rgba_r), .hns_rgba_g(hns_rgba_g), .hns_rgba_b(hns_rgba_b),
        .hns_rgba_a(hns_rgba_a), .hns_vector_mag(hns_vector_mag),
        .hns_energy(hns_energy), .hns_entropy(hns_entropy), .hns_phi(hns_phi),
        .hns_phase_coh(hns_phase_coh), .hns_valid(hns_valid),
        .debug_reg_0(debug_reg_0), .debug_reg_1(debug_reg_1),
        .debug_reg_2(debug_reg_2), .debug_reg_3(debug_reg_3)
    );

    typedef struct {
        logic [31:0]  nonce;
        logic [255:0] h;
        logic [31:0]  r, g, b, a, mag, energy, entropy, phi, pc;
        logic         hit;
    } exp_t;

    exp_t        sb[$];
    exp_t        cur;
    int          errors = 0;
    int          checks = 0;
    int          hv_pulses = 0;
    int          busy_cycles;
    int          first_hv;
    logic [15:0] pwr_busy;
    logic [23:0] model_aprev = '0;
    bit          saw_hns = 1'b0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference hash: seed then ROUNDS simultaneous-lane rounds
    function automatic logic [255:0] ref_hash(input logic [255:0] hdr, input logic [31:0] n);
        logic [31:0]  l[8];
        logic [31:0]  nx[8];
        logic [31:0]  kc;
        logic [255:0] res;
        for (int k = 0; k < 8; k++) l[k] = hdr[32*k +: 32] ^ n;
        for (int i = 0; i < ROUNDS; i++) begin
            kc = 32'h9E3779B9 * 32'(i + 1);
            for (int k = 0; k < 8; k++)
                nx[k] = {l[k][24:0], l[k][31:25]} ^ (l[(k + 1) % 8] + kc);
            for (int k = 0; k < 8; k++) l[k] = nx[k];
        end
        for (int k = 0; k < 8; k++) res[32*k +: 32] = l[k];
        return res;
    endfunction

    task automatic push_job(input logic [255:0] hdr, input logic [31:0] sn,
                            input logic [31:0] rng, input logic [4:0] d);
        int unsigned cnt;
        cnt = (rng == 0) ? 1 : rng;
        for (int unsigned j = 0; j < cnt; j++) begin
            exp_t        e;
            logic [23:0] mx, df;
            logic [31:0] top;
            int          pop;
            e.nonce = sn + j;
            e.h     = ref_hash(hdr, e.nonce);
            e.r = {8'h0, e.h[255:232]};
            e.g = {8'h0, e.h[191:168]};
            e.b = {8'h0, e.h[127:104]};
            e.a = {8'h0, e.h[63:40]};
            mx = e.r[23:0];
            if (e.g[23:0] > mx) mx = e.g[23:0];
            if (e.b[23:0] > mx) mx = e.b[23:0];
            e.mag    = {8'h0, (mx >> 1) | 24'd1};
            e.energy = (e.r + e.g + e.b + e.a) >> 2;
            pop = 0;
            for (int i = 0; i < 256; i++) pop += int'(e.h[i]);
            e.entropy = 32'(pop) << 16;
            e.phi     = (e.entropy >> 1) + (e.mag >> 1);
            df = (e.a[23:0] >= model_aprev) ? e.a[23:0] - model_aprev : model_aprev - e.a[23:0];
            e.pc = {8'h0, (24'hFFFFFF - df) | 24'd1};
            model_aprev = e.a[23:0];
            top = e.h[255:224];
            e.hit = (d == 0) || ((top >> (32 - int'(d))) == 0);
            sb.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (saw_hns) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 1, 0);
            end else begin
                cur = sb.pop_front();
                check("rgba_r", hns_rgba_r, cur.r);
                check("rgba_g", hns_rgba_g, cur.g);
                check("rgba_b", hns_rgba_b, cur.b);
                check("rgba_a", hns_rgba_a, cur.a);
                check("mag", hns_vector_mag, cur.mag);
                check("energy", hns_energy, cur.energy);
                check("entropy", hns_entropy, cur.entropy);
                check("phi", hns_phi, cur.phi);
                check("phase_coh", hns_phase_coh, cur.pc);
                check("hash_valid", hash_valid, cur.hit);
                check("hns_valid_set", hns_valid, 1);
                if (cur.hit) begin
                    check("found_nonce", found_nonce, cur.nonce);
                    check("found_hash", found_hash, cur.h);
                end
            end
        end
        saw_hns = !reset_n && (status_reg[1:0] == 2'd2);
        if (hash_valid) hv_pulses++;
    end

    task automatic run_job(input logic [255:0] hdr, input logic [31:0] sn,
                           input logic [31:0] rng, input logic [15:0] cfg);
        @(negedge clk);
        job_header  = hdr;
        start_nonce = sn;
        nonce_range = rng;
        config_reg  = cfg;
        control_reg = 8'h01;
        push_job(hdr, sn, rng, cfg[4:0]);
        hv_pulses   = 0;
        busy_cycles = 0;
        first_hv    = 0;
        pwr_busy    = '0;
        mining_enable = 1'b1;
        for (int c = 1; c <= 2000; c++) begin
            @(negedge clk);
            if (pipeline_busy) begin
                busy_cycles++;
                pwr_busy = power_consumption;
            end
            if (hns_valid && first_hv == 0) first_hv = c;
            if (status_reg[1:0] == 2'd3) break;
        end
        check("job_done_state", status_reg[1:0], 2'd3);
        @(negedge clk);
    endtask

    task automatic stop_job();
        mining_enable = 1'b0;
        @(negedge clk);
        check("idle_after_stop", status_reg[1:0], 2'd0);
        check("hns_valid_cleared", hns_valid, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [255:0] hdr;
        reset_n = 1'b1;
        job_header = '0; start_nonce = '0; nonce_range = '0; mining_enable = 1'b0;
        control_reg = '0; config_reg = '0;
        uart_rx = 1'b1; spi_clk = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;

        repeat (10) @(negedge clk);
        check("rst_found_nonce", found_nonce, 0);
        check("rst_found_hash", found_hash, 0);
        check("rst_hash_valid", hash_valid, 0);
        check("rst_busy", pipeline_busy, 0);
        check("rst_temp", temperature, 40);
        check("rst_power", power_consumption, 500);
        check("rst_throttle", thermal_throttle, 0);
        check("rst_status", status_reg, 0);
        check("rst_uart_tx", uart_tx, 1);
        check("rst_spi_miso", spi_miso, 0);
        check("rst_hns_valid", hns_valid, 0);
        check("rst_rgba", {hns_rgba_r, hns_rgba_g, hns_rgba_b, hns_rgba_a}, 0);
        check("rst_metrics", {hns_vector_mag, hns_energy, hns_entropy, hns_phi, hns_phase_coh}, 0);
        check("rst_dbg012", {debug_reg_0, debug_reg_1, debug_reg_2}, 0);
`ifdef BM1387_DEBUG_EN
        check("rst_dbg3", debug_reg_3, 32'd40);
`else
        check("rst_dbg3", debug_reg_3, 0);
`endif
        reset_n = 1'b0;
        @(negedge clk);

        // Reference pattern, single nonce
        run_job({2{128'h123456789ABCDEF0FEDCBA9876543210}}, 32'h0000_1000, 32'd1, 16'h0000);
        check("hns_latency", first_hv, ROUNDS + 3);
        check("busy_cycles_1", busy_cycles, ROUNDS + 2);
        check("power_busy", pwr_busy, 1200);
        check("r_bound", hns_rgba_r <= 32'h01000000, 1);
        check("g_bound", hns_rgba_g <= 32'h01000000, 1);
        check("b_bound", hns_rgba_b <= 32'h01000000, 1);
        check("a_bound", hns_rgba_a <= 32'h01000000, 1);
        check("mag_bound", hns_vector_mag <= 32'h01000000, 1);
        stop_job();
        check("power_idle", power_consumption, 500);

        // All-ones header
        run_job({256{1'b1}}, 32'd0, 32'd1, 16'h0000);
        check("metrics_nonzero", (hns_energy | hns_entropy | hns_phi) != 0, 1);
        check("energy_bound", hns_energy <= 32'h01000000, 1);
        check("entropy_bound", hns_entropy <= 32'h01000000, 1);
        check("phi_bound", hns_phi <= 32'h01000000, 1);
        stop_job();

        run_job({8{32'h0080FF00}}, 32'd7, 32'd1, 16'h0000);
        check("mag_range", (hns_vector_mag > 0) && (hns_vector_mag < 32'h00800000), 1);
        stop_job();

        run_job({32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8}, 32'd3, 32'd0, 16'h0000);
        check("phase_coh_nonzero", hns_phase_coh != 0, 1);
        stop_job();

        // Five nonces, every hash hits at difficulty 0
        for (int i = 0; i < 32; i++) hdr[255 - 8*i -: 8] = 8'(i);
        run_job(hdr, 32'd0, 32'd5, 16'h0000);
        check("busy_cycles_5", busy_cycles, 5 * (ROUNDS + 2));
        check("hit_pulses_5", hv_pulses, 5);
        check("found_nonce_last", found_nonce, 4);
        check("sticky_set", status_reg[5], 1);
        check("hns_valid_done", hns_valid, 1);
        stop_job();

        // Difficulty 31: no hits expected, sticky cleared by the new start
        run_job(hdr, 32'd100, 32'd3, 16'h001F);
        check("hit_pulses_d31", hv_pulses, 0);
        check("sticky_cleared", status_reg[5], 0);
        stop_job();

        // Abort in the middle of hashing
        @(negedge clk);
        job_header = {8{32'hCAFEF00D}}; start_nonce = 32'd9; nonce_range = 32'd1;
        config_reg = 16'h001F; control_reg = 8'h01;
        mining_enable = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (status_reg[1:0] == 2'd1) break;
        end
        repeat (3) @(negedge clk);
        check("abort_in_hash", status_reg[1:0], 2'd1);
        mining_enable = 1'b0;
        @(negedge clk);
        check("abort_idle", status_reg[1:0], 2'd0);
        check("abort_busy", pipeline_busy, 0);
        check("abort_hns_valid", hns_valid, 0);
        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
